// File: rtl/sm_cache_controller.sv
// sm_cache_controller: cache-side MSI coherence controller for a single-line cache.
// Rev 1.0
`default_nettype none

module sm_cache_controller #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cpuRead,
  input  logic             cpuWrite,
  input  logic [TAG_W-1:0] cpuTag,
  input  logic             fetchIn,
  input  logic             invalidateIn,
  input  logic             dataValueReply,
  output logic             readMiss,
  output logic             writeMiss,
  output logic             writeBack,
  output logic             fetchAck,
  output logic [TAG_W-1:0] busTag,
  output logic             cpuDone,
  output logic [TAG_W-1:0] lineTag,
  output logic [2:0]       currentState
);

  typedef enum logic [2:0] {
    ST_I      = 3'b000,
    ST_S      = 3'b001,
    ST_M      = 3'b010,
    ST_WAIT_S = 3'b011,
    ST_WAIT_M = 3'b100,
    ST_WB     = 3'b101
  } state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] lineTag_q, lineTag_d;
  logic [TAG_W-1:0] busTag_q, busTag_d;
  logic             readMiss_q, readMiss_d;
  logic             writeMiss_q, writeMiss_d;
  logic             writeBack_q, writeBack_d;
  logic             fetchAck_q, fetchAck_d;
  logic             cpuDone_q, cpuDone_d;

  logic req_w;
  logic hit_tag_w;

  // A request still held during its own cpuDone cycle must not be served twice.
  assign req_w     = (cpuRead | cpuWrite) & ~cpuDone_q;
  assign hit_tag_w = (lineTag_q == cpuTag);

  always_comb begin
    state_d     = state_q;
    lineTag_d   = lineTag_q;
    busTag_d    = '0;
    readMiss_d  = 1'b0;
    writeMiss_d = 1'b0;
    writeBack_d = 1'b0;
    fetchAck_d  = 1'b0;
    cpuDone_d   = 1'b0;

    unique case (state_q)
      ST_I: begin
        if (req_w) begin
          lineTag_d = cpuTag;
          busTag_d  = cpuTag;
          if (cpuWrite) begin
            writeMiss_d = 1'b1;
            state_d     = ST_WAIT_M;
          end else begin
            readMiss_d = 1'b1;
            state_d    = ST_WAIT_S;
          end
        end
      end
      ST_S: begin
        if (invalidateIn) begin
          state_d = ST_I;
        end else if (req_w) begin
          if (hit_tag_w && !cpuWrite) begin
            cpuDone_d = 1'b1;
          end else begin
            // Upgrade on a write hit; otherwise the clean line is dropped silently.
            lineTag_d = cpuTag;
            busTag_d  = cpuTag;
            if (cpuWrite) begin
              writeMiss_d = 1'b1;
              state_d     = ST_WAIT_M;
            end else begin
              readMiss_d = 1'b1;
              state_d    = ST_WAIT_S;
            end
          end
        end
      end
      ST_M: begin
        if (fetchIn) begin
          fetchAck_d = 1'b1;
          busTag_d   = lineTag_q;
          state_d    = invalidateIn ? ST_I : ST_S;
        end else if (invalidateIn) begin
          state_d = ST_I;
        end else if (req_w) begin
          if (hit_tag_w) begin
            cpuDone_d = 1'b1;
          end else begin
            writeBack_d = 1'b1;
            busTag_d    = lineTag_q;
            state_d     = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_d = ST_I;
      end
      ST_WAIT_S: begin
        if (dataValueReply) begin
          cpuDone_d = 1'b1;
          state_d   = ST_S;
        end
      end
      ST_WAIT_M: begin
        if (dataValueReply) begin
          cpuDone_d = 1'b1;
          state_d   = ST_M;
        end
      end
      default: begin
        state_d = ST_I;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_I;
      lineTag_q   <= '0;
      busTag_q    <= '0;
      readMiss_q  <= 1'b0;
      writeMiss_q <= 1'b0;
      writeBack_q <= 1'b0;
      fetchAck_q  <= 1'b0;
      cpuDone_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lineTag_q   <= lineTag_d;
      busTag_q    <= busTag_d;
      readMiss_q  <= readMiss_d;
      writeMiss_q <= writeMiss_d;
      writeBack_q <= writeBack_d;
      fetchAck_q  <= fetchAck_d;
      cpuDone_q   <= cpuDone_d;
    end
  end

  assign readMiss     = readMiss_q;
  assign writeMiss    = writeMiss_q;
  assign writeBack    = writeBack_q;
  assign fetchAck     = fetchAck_q;
  assign busTag       = busTag_q;
  assign cpuDone      = cpuDone_q;
  assign lineTag      = lineTag_q;
  assign currentState = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_cache_controller.sv
// tb_sm_cache_controller: directed-vector bench for the single-line MSI cache controller.
// Rev 1.0
`default_nettype none

module tb_sm_cache_controller;

  localparam int TAG_W = 4;

  logic             clock;
  logic             resetn;
  logic             cpuRead;
  logic             cpuWrite;
  logic [TAG_W-1:0] cpuTag;
  logic             fetchIn;
  logic             invalidateIn;
  logic             dataValueReply;
  logic             readMiss;
  logic             writeMiss;
  logic             writeBack;
  logic             fetchAck;
  logic [TAG_W-1:0] busTag;
  logic             cpuDone;
  logic [TAG_W-1:0] lineTag;
  logic [2:0]       currentState;

  int nvec = 0;
  int nerr = 0;

  sm_cache_controller #(.TAG_W(TAG_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cpuRead        (cpuRead),
    .cpuWrite       (cpuWrite),
    .cpuTag         (cpuTag),
    .fetchIn        (fetchIn),
    .invalidateIn   (invalidateIn),
    .dataValueReply (dataValueReply),
    .readMiss       (readMiss),
    .writeMiss      (writeMiss),
    .writeBack      (writeBack),
    .fetchAck       (fetchAck),
    .busTag         (busTag),
    .cpuDone        (cpuDone),
    .lineTag        (lineTag),
    .currentState   (currentState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; outputs are then stable for checking.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses packed as {readMiss, writeMiss, writeBack, fetchAck, cpuDone}.
  function automatic logic [7:0] pulses();
    return {3'b000, readMiss, writeMiss, writeBack, fetchAck, cpuDone};
  endfunction

  initial begin
    resetn = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0; cpuTag = '0;
    fetchIn = 1'b0; invalidateIn = 1'b0; dataValueReply = 1'b0;

    // Reset then read miss
    step(); step();
    chk("rst_state", 8'(currentState), 8'h0);
    chk("rst_tag", 8'(lineTag), 8'h0);
    chk("rst_pulses", pulses(), 8'h00);
    chk("rst_bustag", 8'(busTag), 8'h0);
    resetn = 1'b1; cpuRead = 1'b1; cpuTag = 4'd3;
    step();
    chk("rm_pulses", pulses(), 8'h10);
    chk("rm_bustag", 8'(busTag), 8'h3);
    chk("rm_state", 8'(currentState), 8'h3);
    step();
    chk("rm_oneshot", pulses(), 8'h00);
    dataValueReply = 1'b1;
    step();
    chk("rm_done", pulses(), 8'h01);
    chk("rm_state_s", 8'(currentState), 8'h1);
    chk("rm_linetag", 8'(lineTag), 8'h3);
    dataValueReply = 1'b0;
    step();
    // cpuRead was still high at that edge, but cpuDone blocks re-service
    chk("no_double", pulses(), 8'h00);
    cpuRead = 1'b0;

    // Read hit in S
    cpuRead = 1'b1;
    step();
    chk("rhit_done", pulses(), 8'h01);
    cpuRead = 1'b0;
    step();

    // Upgrade S -> WAIT_M -> M
    cpuWrite = 1'b1; cpuTag = 4'd3;
    step();
    chk("upg_pulses", pulses(), 8'h08);
    chk("upg_bustag", 8'(busTag), 8'h3);
    chk("upg_state", 8'(currentState), 8'h4);
    dataValueReply = 1'b1;
    step();
    chk("upg_done", pulses(), 8'h01);
    chk("upg_state_m", 8'(currentState), 8'h2);
    cpuWrite = 1'b0; dataValueReply = 1'b0;
    step();

    // Fetch while M -> S
    fetchIn = 1'b1;
    step();
    chk("fetch_ack", pulses(), 8'h02);
    chk("fetch_state", 8'(currentState), 8'h1);
    fetchIn = 1'b0;
    step();
    chk("fetch_oneshot", pulses(), 8'h00);

    // Back to M, then fetch+invalidate -> I
    cpuWrite = 1'b1;
    step();
    dataValueReply = 1'b1;
    step();
    chk("m_again", 8'(currentState), 8'h2);
    cpuWrite = 1'b0; dataValueReply = 1'b0;
    step();
    fetchIn = 1'b1; invalidateIn = 1'b1;
    step();
    chk("fi_ack", pulses(), 8'h02);
    chk("fi_state", 8'(currentState), 8'h0);
    fetchIn = 1'b0; invalidateIn = 1'b0;
    step();

    // Get to S, then invalidate wins over a simultaneous read
    cpuRead = 1'b1;
    step();
    dataValueReply = 1'b1;
    step();
    chk("s_again", 8'(currentState), 8'h1);
    cpuRead = 1'b0; dataValueReply = 1'b0;
    step();
    cpuRead = 1'b1; invalidateIn = 1'b1;
    step();
    chk("inv_state", 8'(currentState), 8'h0);
    chk("inv_pulses", pulses(), 8'h00);
    invalidateIn = 1'b0;
    step();
    chk("inv_rm", pulses(), 8'h10);
    chk("inv_rm_tag", 8'(busTag), 8'h3);
    dataValueReply = 1'b1;
    step();
    chk("inv_done", pulses(), 8'h01);
    cpuRead = 1'b0; dataValueReply = 1'b0;
    step();

    // Write with tag mismatch in S: silent eviction, write miss for tag 5
    cpuWrite = 1'b1; cpuTag = 4'd5;
    step();
    chk("sev_pulses", pulses(), 8'h08);
    chk("sev_bustag", 8'(busTag), 8'h5);
    chk("sev_linetag", 8'(lineTag), 8'h5);
    dataValueReply = 1'b1;
    step();
    chk("sev_state_m", 8'(currentState), 8'h2);
    cpuWrite = 1'b0; dataValueReply = 1'b0;
    step();

    // Write hit in M
    cpuWrite = 1'b1;
    step();
    chk("mhit_done", pulses(), 8'h01);
    cpuWrite = 1'b0;
    step();

    // Dirty eviction: M tag 5, read tag 6
    cpuRead = 1'b1; cpuTag = 4'd6;
    step();
    chk("wb_pulses", pulses(), 8'h04);
    chk("wb_bustag", 8'(busTag), 8'h5);
    chk("wb_state", 8'(currentState), 8'h5);
    step();
    chk("wb_to_i", 8'(currentState), 8'h0);
    chk("wb_nodone", pulses(), 8'h00);
    step();
    chk("wb_rm", pulses(), 8'h10);
    chk("wb_rm_tag", 8'(busTag), 8'h6);
    chk("wb_linetag", 8'(lineTag), 8'h6);
    dataValueReply = 1'b1;
    step();
    chk("wb_done", pulses(), 8'h01);
    chk("wb_state_s", 8'(currentState), 8'h1);
    cpuRead = 1'b0; dataValueReply = 1'b0;
    step();

    // Reset mid-miss: reset and reply at the same edge
    cpuWrite = 1'b1;
    step();
    chk("rmm_wait", 8'(currentState), 8'h4);
    dataValueReply = 1'b1; resetn = 1'b0;
    step();
    chk("rmm_state", 8'(currentState), 8'h0);
    chk("rmm_pulses", pulses(), 8'h00);
    chk("rmm_linetag", 8'(lineTag), 8'h0);
    resetn = 1'b1; cpuWrite = 1'b0;
    step();
    chk("rmm_late_reply", pulses(), 8'h00);
    chk("rmm_stay_i", 8'(currentState), 8'h0);
    dataValueReply = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_cache_controller.md
# sm_cache_controller

Per-node cache-side MSI coherence controller for a single-line cache. It sits directly upstream of the directory state machine. It turns processor read/write requests into one-cycle `readMiss`/`writeMiss`/`writeBack` messages to the directory. It also consumes the directory's `fetch`, `invalidateOut` and `dataValueReply` outputs to keep the local line state coherent.

## Interface
- `TAG_W`, default 4: width of the block tag held for the line.
- `clock` input 1: single clock; all state changes on posedge.
- `resetn` input 1: synchronous, active-low reset.
- `cpuRead` input 1: processor read request; held until `cpuDone`.
- `cpuWrite` input 1: processor write request; held until `cpuDone`. Wins over `cpuRead` if both are high.
- `cpuTag` input TAG_W: tag of the requested block; stable while a request is held.
- `fetchIn` input 1: directory fetch (owner must supply data).
- `invalidateIn` input 1: directory invalidate.
- `dataValueReply` input 1: directory data reply completing a pending miss.
- `readMiss` output 1: one-cycle read-miss message.
- `writeMiss` output 1: one-cycle write-miss/upgrade message.
- `writeBack` output 1: one-cycle write-back message (eviction of a Modified line).
- `fetchAck` output 1: one-cycle pulse; data supplied in response to `fetchIn`.
- `busTag` output TAG_W: tag accompanying any outgoing message; valid while that message is high.
- `cpuDone` output 1: one-cycle completion pulse for the held request.
- `lineTag` output TAG_W: current stored tag.
- `currentState` output 3: line state encoding.
  - 000 I
  - 001 S
  - 010 M
  - 011 WAIT_S
  - 100 WAIT_M
  - 101 WB

## Operation
- All outputs are registered. Every pulse output defaults to 0 each cycle.
- Hit means `lineTag == cpuTag` and the state is S or M.
- **Request acceptance.** A request is ignored in any cycle where `cpuDone` is currently 1. This prevents double service.
- **Directory priority.** In S or M, a directory message (`invalidateIn`/`fetchIn`) is processed in the same cycle in place of any CPU request. The CPU request stays held and is serviced later from the new state.
- **I:**
  - write → `writeMiss`=1, `busTag`=`cpuTag`, `lineTag`←`cpuTag`, go to WAIT_M.
  - read → `readMiss`=1, same tag handling, go to WAIT_S.
  - Directory inputs are ignored.
- **S:**
  - `invalidateIn` → I.
  - read hit → `cpuDone`=1.
  - write hit → `writeMiss`=1 (upgrade), go to WAIT_M.
  - Read or write with tag mismatch → silent eviction, then issue the miss exactly as from I.
- **M:**
  - `fetchIn` & `invalidateIn` → `fetchAck`=1, go to I.
  - `fetchIn` alone → `fetchAck`=1, go to S.
  - read/write hit → `cpuDone`=1.
  - Tag mismatch with a request → `writeBack`=1, `busTag`=old `lineTag`, go to WB.
- **WB:** lasts one cycle, then go to I with no `cpuDone`. The held request then misses from I.
- **WAIT_S:** `dataValueReply` → S, `cpuDone`=1.
- **WAIT_M:** `dataValueReply` → M, `cpuDone`=1.
- In WAIT states, `fetchIn`/`invalidateIn` are ignored. The directory has already serialized this node's request.
- Codes 110 and 111 are unreachable; if entered, go to I.

## Timing
- **Reset:** when `resetn`=0 at a posedge:
  - state I, `lineTag`=0;
  - `readMiss`, `writeMiss`, `writeBack`, `fetchAck`, `cpuDone`, `busTag` all 0.
  - Reset overrides every other input, including mid-miss. A pending reply arriving afterward is ignored in I.
- **Hit latency:** request sampled at edge N, `cpuDone` high for the cycle after edge N.
- **Miss latency with the directory attached:**
  - edge N: request accepted, message asserted;
  - edge N+1: directory samples the message and asserts `dataValueReply`;
  - edge N+2: `cpuDone`=1.
- **Eviction from M:** `writeBack` after edge N, WB until edge N+1, miss message after edge N+2, `cpuDone` after edge N+4.
- Each message pulse lasts exactly one cycle, never back-to-back from a single request.

## Test plan
- **Reset, then read miss:** `resetn`=0 for 2 cycles, then `cpuRead`=1, `cpuTag`=3.
  - `readMiss`=1 with `busTag`=3 for one cycle.
  - Reply one cycle later → state 001, `cpuDone` one cycle, `lineTag`=3.
- **Upgrade:** in S with tag 3, `cpuWrite`, tag 3 → `writeMiss`=1, state 100. Reply → state 010, `cpuDone`.
- **Invalidate vs request:** in S, `invalidateIn`=1 and `cpuRead`=1 in the same cycle.
  - State goes to 000 with no `cpuDone`.
  - Next cycle `readMiss`=1.
- **Fetch while M:** in M, `fetchIn`=1 → `fetchAck`=1, state 001. `fetchIn`+`invalidateIn` → `fetchAck`=1, state 000.
- **Dirty eviction:** in M with tag 5, `cpuRead` with tag 6.
  - `writeBack`=1 with `busTag`=5, state 101.
  - Then state 000, then `readMiss` with `busTag`=6.
  - Reply → `cpuDone`, state 001.
- **Reset mid-miss:** in WAIT_M, `resetn`=0 at the same edge as `dataValueReply`=1 → state 000, `cpuDone`=0.
